rf_wport_arbiter: RTL



---
 rtl/rf_wport_arbiter.sv | 84 ++++++++
 1 files changed

// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the regfile write port between pipeline writeback and a buffered long-latency port, with a busy scoreboard
module rf_wport_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wa_we_i,
  input  logic [4:0]  wa_waddr_i,
  input  logic [31:0] wa_wdata_i,
  input  logic        wb_valid_i,
  output logic        wb_ready_o,
  input  logic [4:0]  wb_waddr_i,
  input  logic [31:0] wb_wdata_i,
  input  logic        iss_valid_i,
  input  logic [4:0]  iss_waddr_i,
  input  logic        re1_i,
  input  logic        re2_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic        rd_stall_o,
  output logic        pipe_hold_o,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [4:0]    fa [DEPTH];
  logic [31:0]   fd [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0]   cnt;
  logic [31:1]   busy;
  logic [31:0]   busy_x, set_v, clr_v, busy_nxt;
  logic [SW-1:0] starve, starve_nxt;
  logic          a_act, empty, full, drain, push;
  logic [4:0]    head_a;
  assign a_act      = wa_we_i & (wa_waddr_i != 5'd0) & !rst;
  assign empty      = cnt == '0;
  assign full       = cnt == (AW+1)'(DEPTH);
  assign drain      = !a_act & !empty;
  assign wb_ready_o = !full & !rst;
  assign push       = wb_valid_i & wb_ready_o & (wb_waddr_i != 5'd0);
  assign head_a     = fa[rp];
  assign we_o       = a_act | drain;
  assign waddr_o    = a_act ? wa_waddr_i : drain ? head_a : 5'd0;
  assign wdata_o    = a_act ? wa_wdata_i : drain ? fd[rp] : 32'd0;
  assign busy_x     = {busy, 1'b0};
  assign rd_stall_o = (re1_i & busy_x[raddr1_i] & !(drain & head_a == raddr1_i))
                    | (re2_i & busy_x[raddr2_i] & !(drain & head_a == raddr2_i))
                    | (iss_valid_i & busy_x[iss_waddr_i] & !(drain & head_a == iss_waddr_i));
  // scoreboard and starvation next-state: issue beats drain on the same register
  always_comb begin
    set_v      = iss_valid_i ? 32'd1 << iss_waddr_i : 32'd0;
    clr_v      = drain ? 32'd1 << head_a : 32'd0;
    busy_nxt   = (busy_x & ~clr_v) | set_v;
    starve_nxt = (empty | drain) ? '0 : (starve == SW'(STARVE_MAX)) ? starve : starve + 1'b1;
  end
  // FIFO storage needs no reset; validity comes from the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      fa[wp] <= wb_waddr_i;
      fd[wp] <= wb_wdata_i;
    end
  end
  // pointers, occupancy, busy bitmap, starvation counter and hold flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp          <= '0;
      wp          <= '0;
      cnt         <= '0;
      busy        <= '0;
      starve      <= '0;
      pipe_hold_o <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (drain) rp <= rp + 1'b1;
      cnt         <= cnt + (AW+1)'(push) - (AW+1)'(drain);
      busy        <= busy_nxt[31:1];
      starve      <= starve_nxt;
      pipe_hold_o <= drain ? 1'b0 : (pipe_hold_o | (starve_nxt == SW'(STARVE_MAX)));
    end
  end
endmodule
